// File: rtl/reg_write_pkg.sv
// reg_write_pkg: shared definitions for the register-file writeback stage.
//   - in_src encodings (FPU->i32, FPU->u32, ALU, memory, FPU->fp32)
//   - FIFO entry layout {rd, data}
//   - IEEE-754 single-precision field constants
// The FIFO entry fields are sized to the largest supported register index
// and data widths; instances zero-extend narrower values into them, so
// synthesis trims the constant upper bits.
package reg_write_pkg;

    localparam logic [2:0] SRC_FPU_I32 = 3'b000;
    localparam logic [2:0] SRC_FPU_U32 = 3'b001;
    localparam logic [2:0] SRC_ALU     = 3'b010;  // 01x
    localparam logic [2:0] SRC_MEM     = 3'b100;  // 10x
    localparam logic [2:0] SRC_FPU_F32 = 3'b110;  // 11x

    localparam int FP32_BIAS     = 127;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_MANT_W   = 23;

    localparam int RW_ADDR_MAX_W = 8;
    localparam int RW_DATA_MAX_W = 64;

    typedef struct packed {
        logic [RW_ADDR_MAX_W-1:0] rd;
        logic [RW_DATA_MAX_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/reg_write_pipe_q_convert.sv
// q_convert: combinational conversion of a two's-complement fixed-point
// FPU result Q(FPU_W-FRAC_W).FRAC_W into integer and float forms.
//   fpu_res  in   FPU_W   fixed-point source value
//   i32_res  out  DATA_W  floor(fpu_res / 2^FRAC_W), signed
//   u32_res  out  DATA_W  same shift, unsigned interpretation
//   f32_res  out  DATA_W  IEEE single, mantissa truncated, zero -> +0.0
// Configuration macro: REG_WRITE_SAT_EN -- when defined, i32/u32 saturate
// to their ranges instead of keeping the low DATA_W bits.
module q_convert
    import reg_write_pkg::*;
#(
    parameter int FPU_W  = 64,
    parameter int FRAC_W = 15,
    parameter int DATA_W = 32
) (
    input  logic [FPU_W-1:0]  fpu_res,
    output logic [DATA_W-1:0] i32_res,
    output logic [DATA_W-1:0] u32_res,
    output logic [DATA_W-1:0] f32_res
);

`ifdef REG_WRITE_SAT_EN
    logic signed [FPU_W-1:0]  shifted;
    logic        [FPU_W-DATA_W:0] upper;

    assign shifted = $signed(fpu_res) >>> FRAC_W;
    // Bits from DATA_W-1 upward must all equal the sign for an in-range i32.
    assign upper   = shifted[FPU_W-1:DATA_W-1];

    always_comb begin
        i32_res = shifted[DATA_W-1:0];
        if (upper != '0 && upper != '1) begin
            i32_res = shifted[FPU_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        u32_res = shifted[DATA_W-1:0];
        if (shifted[FPU_W-1]) begin
            u32_res = '0;
        end else if (shifted[FPU_W-1:DATA_W] != '0) begin
            u32_res = '1;
        end
    end
`else
    // Floor shift then truncation is just a bit-field extract.
    assign i32_res = fpu_res[FRAC_W +: DATA_W];
    assign u32_res = fpu_res[FRAC_W +: DATA_W];
`endif

    logic                   f_sign;
    logic [FPU_W-1:0]       f_mag;
    int                     f_lead;
    logic [FP32_EXP_W-1:0]  f_exp;
    logic [FP32_MANT_W-1:0] f_mant;
    logic [31:0]            f_bits;

    always_comb begin
        f_sign = fpu_res[FPU_W-1];
        // Negating the most negative value yields 2^(FPU_W-1), which is the
        // correct magnitude when read as unsigned.
        f_mag  = f_sign ? (~fpu_res + 1'b1) : fpu_res;
        f_lead = 0;
        for (int unsigned i = 0; i < FPU_W; i++) begin
            if (f_mag[i]) begin
                f_lead = int'(i);
            end
        end
        f_exp = FP32_EXP_W'(FP32_BIAS + f_lead - FRAC_W);
        // Mantissa = the bits just below the leading one, truncated.
        for (int unsigned j = 0; j < FP32_MANT_W; j++) begin
            f_mant[FP32_MANT_W-1-j] = (f_lead > int'(j)) ? f_mag[f_lead-1-int'(j)] : 1'b0;
        end
        f_bits = {f_sign, f_exp, f_mant};
        if (f_mag == '0) begin
            f_bits = '0;
        end
    end

    assign f32_res = DATA_W'(f_bits);

endmodule

// File: rtl/reg_write_pipe.sv
// reg_write_pipe: pipelined register-file writeback stage.
//   S1 register holds the raw accepted request; q_convert on the S1 output
//   selects/converts the data, which is pushed into a DEPTH-entry circular
//   FIFO feeding the register-file write port.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     request handshake
//   in_src, in_rd         source select, destination register
//   alu_res, mem_read_data, fpu_res   candidate results
//   out_valid/out_ready   register-file write handshake (FIFO head)
//   out_rd, out_data      head destination and data (0 when empty)
//   fwd_rd                forwarding lookup index
//   fwd_hit, fwd_data     youngest pending write to fwd_rd (data 0 on miss)
// Configuration macro: REG_WRITE_SAT_EN (saturating i32/u32, in q_convert).
module reg_write_pipe
    import reg_write_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FPU_W  = 64,
    parameter int FRAC_W = 15,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_src,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [FPU_W-1:0]  fpu_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_data,
    input  logic [ADDR_W-1:0] fwd_rd,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              s1_valid;
    logic [2:0]        s1_src;
    logic [ADDR_W-1:0] s1_rd;
    logic [DATA_W-1:0] s1_alu;
    logic [DATA_W-1:0] s1_mem;
    logic [FPU_W-1:0]  s1_fpu;

    logic [DATA_W-1:0] cv_i32;
    logic [DATA_W-1:0] cv_u32;
    logic [DATA_W-1:0] cv_f32;
    logic [DATA_W-1:0] s1_data;

    fifo_entry_t       fifo_mem [DEPTH];
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  fwd_slot;

    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              s1_zero_rd;
    logic              s1_drain;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    q_convert #(
        .FPU_W (FPU_W),
        .FRAC_W(FRAC_W),
        .DATA_W(DATA_W)
    ) u_q_convert (
        .fpu_res(s1_fpu),
        .i32_res(cv_i32),
        .u32_res(cv_u32),
        .f32_res(cv_f32)
    );

    always_comb begin
        s1_data = s1_alu;
        if (s1_src == SRC_FPU_I32) begin
            s1_data = cv_i32;
        end else if (s1_src == SRC_FPU_U32) begin
            s1_data = cv_u32;
        end else if (s1_src[2:1] == SRC_ALU[2:1]) begin
            s1_data = s1_alu;
        end else if (s1_src[2:1] == SRC_MEM[2:1]) begin
            s1_data = s1_mem;
        end else if (s1_src[2:1] == SRC_FPU_F32[2:1]) begin
            s1_data = cv_f32;
        end
    end

    // in_ready counts S1 as a FIFO slot already spoken for, so an accepted
    // request always finds room for the S1 entry it displaces; out_ready is
    // deliberately left out to keep it off the in_ready path.
    assign in_ready   = !reset && (({31'd0, s1_valid} + 32'(count)) < 32'(DEPTH));
    assign accept     = in_valid && in_ready;

    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign s1_zero_rd = (s1_rd == '0);
    assign push       = s1_valid && !s1_zero_rd && (!fifo_full || pop);
    assign s1_drain   = s1_valid && (s1_zero_rd || !fifo_full || pop);

    always_comb begin
        push_entry      = '0;
        push_entry.rd   = RW_ADDR_MAX_W'(s1_rd);
        push_entry.data = RW_DATA_MAX_W'(s1_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_src   <= '0;
            s1_rd    <= '0;
            s1_alu   <= '0;
            s1_mem   <= '0;
            s1_fpu   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_src   <= in_src;
            s1_rd    <= in_rd;
            s1_alu   <= alu_res;
            s1_mem   <= mem_read_data;
            s1_fpu   <= fpu_res;
        end else if (s1_drain) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_entry;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head     = fifo_mem[rd_ptr];
    assign out_rd   = out_valid ? head.rd[ADDR_W-1:0] : '0;
    assign out_data = out_valid ? head.data[DATA_W-1:0] : '0;

    // Scan oldest to newest so later matches override earlier ones, then
    // let S1 (the youngest write) override everything.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_slot = '0;
        if (fwd_rd != '0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fwd_slot = PTR_W'((32'(rd_ptr) + i) % 32'(DEPTH));
                if (i < 32'(count) && fifo_mem[fwd_slot].rd == RW_ADDR_MAX_W'(fwd_rd)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fifo_mem[fwd_slot].data[DATA_W-1:0];
                end
            end
            if (s1_valid && !s1_zero_rd && s1_rd == fwd_rd) begin
                fwd_hit  = 1'b1;
                fwd_data = s1_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_pipe.sv
// tb_reg_write_pipe: directed self-checking bench for reg_write_pipe.
// Expected saturation results follow REG_WRITE_SAT_EN.
module tb_reg_write_pipe;
    import reg_write_pkg::*;

    localparam int DATA_W = 32;
    localparam int FPU_W  = 64;
    localparam int FRAC_W = 15;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_src;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_read_data;
    logic [FPU_W-1:0]  fpu_res;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_rd;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] fwd_rd;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] popped[$];

    always #5 clk = ~clk;

    reg_write_pipe #(
        .DATA_W(DATA_W),
        .FPU_W (FPU_W),
        .FRAC_W(FRAC_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_src       (in_src),
        .in_rd        (in_rd),
        .alu_res      (alu_res),
        .mem_read_data(mem_read_data),
        .fpu_res      (fpu_res),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd       (out_rd),
        .out_data     (out_data),
        .fwd_rd       (fwd_rd),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
    );

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) popped.push_back(out_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a request and hold it until accepted; returns at the negedge
    // following the accepting edge, with the request in S1.
    task automatic send(input logic [2:0] src, input logic [ADDR_W-1:0] rd,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                        input logic [FPU_W-1:0] fpu);
        int n;
        in_valid      = 1'b1;
        in_src        = src;
        in_rd         = rd;
        alu_res       = alu;
        mem_read_data = mem;
        fpu_res       = fpu;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [ADDR_W-1:0] rd,
                               input logic [DATA_W-1:0] data);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_rd"}, 64'(out_rd), 64'(rd));
        check({tag, "_data"}, 64'(out_data), 64'(data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] exp_u32_neg;
        logic [DATA_W-1:0] exp_i32_big;
`ifdef REG_WRITE_SAT_EN
        exp_u32_neg = 32'h0000_0000;
        exp_i32_big = 32'h7FFF_FFFF;
`else
        exp_u32_neg = 32'hFFFF_FFFE;
        exp_i32_big = 32'h0000_0000;
`endif
        reset = 1'b1; in_valid = 1'b0; in_src = '0; in_rd = '0;
        alu_res = '0; mem_read_data = '0; fpu_res = '0;
        out_ready = 1'b1; fwd_rd = 5'd1;

        // Reset state
        tick(3);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // FPU -> i32, -1.5 floors to -2; latency through S1
        send(SRC_FPU_I32, 5'd3, 32'hDEAD_0001, 32'hDEAD_0002, 64'hFFFF_FFFF_FFFF_4000);
        check("i32_s1_out_valid", {63'd0, out_valid}, 64'd0);
        fwd_rd = 5'd3;
        #1;
        check("i32_s1_fwd_hit", {63'd0, fwd_hit}, 64'd1);
        check("i32_s1_fwd_data", 64'(fwd_data), 64'hFFFF_FFFE);
        tick(1);
        expect_head("i32", 5'd3, 32'hFFFF_FFFE);

        // fp32: 3.0 and 0, back to back
        send(SRC_FPU_F32, 5'd4, '0, '0, 64'h0000_0000_0001_8000);
        send(SRC_FPU_F32, 5'd6, '0, '0, 64'h0);
        expect_head("f32_three", 5'd4, 32'h4040_0000);
        tick(1);
        expect_head("f32_zero", 5'd6, 32'h0000_0000);

        // fp32 of -1.5, u32 of -1.5, memory source, i32 of 2^40
        send(3'b111, 5'd8, '0, '0, 64'hFFFF_FFFF_FFFF_4000);
        tick(1);
        expect_head("f32_neg", 5'd8, 32'hBFC0_0000);
        send(SRC_FPU_U32, 5'd7, '0, '0, 64'hFFFF_FFFF_FFFF_4000);
        tick(1);
        expect_head("u32_neg", 5'd7, exp_u32_neg);
        send(3'b101, 5'd9, 32'h1234_5678, 32'hCAFE_F00D, 64'h0);
        tick(1);
        expect_head("mem", 5'd9, 32'hCAFE_F00D);
        send(SRC_FPU_I32, 5'd10, '0, '0, 64'h0080_0000_0000_0000);
        tick(1);
        expect_head("i32_big", 5'd10, exp_i32_big);
        tick(2);

        // rd 0 is consumed and never written
        send(3'b011, 5'd0, 32'h0000_0055, '0, '0);
        check("rd0_s1_out_valid", {63'd0, out_valid}, 64'd0);
        fwd_rd = 5'd0;
        #1;
        check("rd0_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        tick(1);
        check("rd0_out_valid_1", {63'd0, out_valid}, 64'd0);
        tick(1);
        check("rd0_out_valid_2", {63'd0, out_valid}, 64'd0);

        // Backpressure: two accepted, then in_ready drops; order preserved
        popped.delete();
        out_ready = 1'b0;
        send(SRC_ALU, 5'd1, 32'h11, '0, '0);
        send(SRC_ALU, 5'd2, 32'h22, '0, '0);
        check("bp_in_ready_drop", {63'd0, in_ready}, 64'd0);
        tick(2);
        check("bp_in_ready_held", {63'd0, in_ready}, 64'd0);
        expect_head("bp_stall", 5'd1, 32'h11);
        out_ready = 1'b1;
        send(SRC_ALU, 5'd3, 32'h33, '0, '0);
        send(SRC_ALU, 5'd4, 32'h44, '0, '0);
        tick(5);
        check("bp_pop_count", 64'(popped.size()), 64'd4);
        check("bp_pop0", 64'(popped[0]), 64'h11);
        check("bp_pop1", 64'(popped[1]), 64'h22);
        check("bp_pop2", 64'(popped[2]), 64'h33);
        check("bp_pop3", 64'(popped[3]), 64'h44);

        // Forwarding priority: S1 over FIFO, then newest FIFO over oldest
        out_ready = 1'b0;
        send(SRC_ALU, 5'd5, 32'hA, '0, '0);
        send(SRC_ALU, 5'd5, 32'hB, '0, '0);
        fwd_rd = 5'd5;
        #1;
        check("fwd_s1_hit", {63'd0, fwd_hit}, 64'd1);
        check("fwd_s1_data", 64'(fwd_data), 64'hB);
        tick(1);
        check("fwd_fifo_hit", {63'd0, fwd_hit}, 64'd1);
        check("fwd_fifo_data", 64'(fwd_data), 64'hB);
        fwd_rd = 5'd7;
        #1;
        check("fwd_miss_hit", {63'd0, fwd_hit}, 64'd0);
        check("fwd_miss_data", 64'(fwd_data), 64'd0);
        fwd_rd = 5'd0;
        #1;
        check("fwd_zero_hit", {63'd0, fwd_hit}, 64'd0);
        check("fwd_zero_data", 64'(fwd_data), 64'd0);
        out_ready = 1'b1;
        tick(1);
        fwd_rd = 5'd5;
        #1;
        check("fwd_after_pop_data", 64'(fwd_data), 64'hB);
        tick(3);
        check("fwd_drained_hit", {63'd0, fwd_hit}, 64'd0);

        // Reset mid-operation drops pending writes
        out_ready = 1'b0;
        send(SRC_ALU, 5'd11, 32'h77, '0, '0);
        send(SRC_ALU, 5'd12, 32'h88, '0, '0);
        check("mid_pending_valid", {63'd0, out_valid}, 64'd1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b0;
        #1;
        check("mid_rel_in_ready", {63'd0, in_ready}, 64'd1);
        fwd_rd = 5'd12;
        #1;
        check("mid_rel_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        out_ready = 1'b1;
        tick(2);
        check("mid_rel_out_valid", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
